// File: rtl/mc_main_control.sv
// mc_main_control: Moore main control FSM for the multicycle MIPS datapath.
// Sequences fetch / decode / execute / memory / writeback and drives every
// datapath select and strobe. Memory-access states stall on MemReady.
// Optional build macro ILLEGAL_OP_TRAP_EN: unknown opcodes enter a sticky TRAP
// state (IllegalOp=1) instead of retiring as a 2-cycle NOP.
module mc_main_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       IllegalOp
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXEC     = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDIEXEC = 4'd10,
`ifdef ILLEGAL_OP_TRAP_EN
        ADDIWB   = 4'd11,
        TRAP     = 4'd12
`else
        ADDIWB   = 4'd11
`endif
    } state_t;

    state_t state;

    assign State = state;

    // State register and next-state selection; Op is only looked at in DECODE and MEMADR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (MemReady) state <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXEC;
                        OP_BEQ:       state <= BRANCH;
                        OP_J:         state <= JUMP;
                        OP_ADDI:      state <= ADDIEXEC;
`ifdef ILLEGAL_OP_TRAP_EN
                        default:      state <= TRAP;
`else
                        default:      state <= FETCH;
`endif
                    endcase
                end
                MEMADR:   state <= (Op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:    if (MemReady) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWR:    if (MemReady) state <= FETCH;
                EXEC:     state <= ALUWB;
                ALUWB:    state <= FETCH;
                BRANCH:   state <= FETCH;
                JUMP:     state <= FETCH;
                ADDIEXEC: state <= ADDIWB;
                ADDIWB:   state <= FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
                TRAP:     state <= TRAP;
`endif
                // Unused codes recover to FETCH
                default:  state <= FETCH;
            endcase
        end
    end

    // Output decode from state; strobes are forced low while reset is held
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        IllegalOp   = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE:   ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB:   RegWrite = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP:     IllegalOp = 1'b1;
`endif
            default:  ;
        endcase
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: table-driven directed bench for mc_main_control, plus
// hand-written sequences for reset, illegal opcode and reset during a store.
module tb_mc_main_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    mc_main_control dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .State(State), .IllegalOp(IllegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed output word:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,IllegalOp}
    localparam logic [16:0] E_RST  = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_F1   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_F0   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] E_MADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_MRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_MWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] E_MWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_EXE  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] E_AWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] E_BR   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] E_JMP  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] E_AEX  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_IWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] E_TRAP = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] outs;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [16:0] outs_now();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};
    endfunction

    task automatic check(input string name, input logic [3:0] st, input logic [16:0] outs);
        n_cmp++;
        if (State !== st) begin
            n_bad++;
            $display("FAIL %s state: got %0d, expected %0d", name, State, st);
        end
        n_cmp++;
        if (outs_now() !== outs) begin
            n_bad++;
            $display("FAIL %s outputs: got %b, expected %b", name, outs_now(), outs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st, input logic [16:0] o);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.outs = o;
        vecs.push_back(v);
    endtask

    initial begin
        // R-type
        add(6'h00, 1, 0, E_F1);  add(6'h00, 1, 1, E_DEC);
        add(6'h00, 1, 6, E_EXE); add(6'h00, 1, 7, E_AWB);
        // lw with 2 FETCH stalls and 3 MEMRD stalls; Op scrambled outside DECODE/MEMADR
        add(6'h3F, 0, 0, E_F0);  add(6'h02, 0, 0, E_F0);  add(6'h23, 1, 0, E_F1);
        add(6'h23, 1, 1, E_DEC); add(6'h23, 1, 2, E_MADR);
        add(6'h2B, 0, 3, E_MRD); add(6'h04, 0, 3, E_MRD); add(6'h00, 0, 3, E_MRD);
        add(6'h2B, 1, 3, E_MRD); add(6'h04, 1, 4, E_MWB);
        // sw with one MEMWR stall
        add(6'h2B, 1, 0, E_F1);  add(6'h2B, 1, 1, E_DEC); add(6'h2B, 1, 2, E_MADR);
        add(6'h23, 0, 5, E_MWR); add(6'h23, 1, 5, E_MWR);
        // beq then j
        add(6'h04, 1, 0, E_F1);  add(6'h04, 1, 1, E_DEC); add(6'h04, 1, 8, E_BR);
        add(6'h02, 1, 0, E_F1);  add(6'h02, 1, 1, E_DEC); add(6'h02, 1, 9, E_JMP);
        // addi
        add(6'h08, 1, 0, E_F1);  add(6'h08, 1, 1, E_DEC);
        add(6'h08, 1, 10, E_AEX); add(6'h08, 1, 11, E_IWB);

        // Reset held for 3 cycles with MemReady=1
        rst_n = 1'b0; Op = 6'h00; MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset", 4'd0, E_RST);
        end
        rst_n = 1'b1;

        // Table: one row per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            Op = vecs[i].op;
            MemReady = vecs[i].mr;
            #1;
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].outs);
            step();
        end

        // Illegal opcode
        Op = 6'h3F; MemReady = 1'b1; #1;
        check("ill_fetch", 4'd0, E_F1);
        step();
        check("ill_decode", 4'd1, E_DEC);
        step();
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 20; i++) begin
            Op = 6'(i); MemReady = i[0];
            #1;
            check("trap_hold", 4'd12, E_TRAP);
            step();
        end
        rst_n = 1'b0; #1;
        check("trap_reset", 4'd0, E_RST);
        step();
        rst_n = 1'b1;
`else
        MemReady = 1'b0; #1;
        check("ill_nop", 4'd0, E_F0);
        step();
`endif

        // Reset during a stalled store
        Op = 6'h2B; MemReady = 1'b1; #1;
        check("rsw_fetch", 4'd0, E_F1);
        step();
        check("rsw_decode", 4'd1, E_DEC);
        step();
        check("rsw_memadr", 4'd2, E_MADR);
        step();
        MemReady = 1'b0; #1;
        check("rsw_memwr", 4'd5, E_MWR);
        rst_n = 1'b0; #1;
        check("rsw_reset", 4'd0, E_RST);
        step();
        check("rsw_reset_hold", 4'd0, E_RST);
        rst_n = 1'b1; MemReady = 1'b1; #1;
        check("rsw_release", 4'd0, E_F1);
        step();
        check("rsw_decode2", 4'd1, E_DEC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Drives every datapath select and strobe, including ALUSrcA for the ALU operand-A mux: 0 selects PC, 1 selects register A.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps, decoding the IR opcode.
- Stalls in memory-access states until the memory returns MemReady.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-equal opcode
OP_J, 6'h02, jump opcode
OP_ADDI, 6'h08, add-immediate opcode

Ports:
clk  input  1  rising-edge system clock
rst_n  input  1  asynchronous active-low reset
Op  input  6  IR[31:26], valid from DECODE onward
MemReady  input  1  memory access completes this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load qualified by ALU Zero (external AND)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  writeback data select: 0 = ALUOut, 1 = MDR
RegDst  output  1  destination register select: 0 = rt, 1 = rd
RegWrite  output  1  register file write
ALUSrcA  output  1  operand A select: 0 = PC, 1 = A
ALUSrcB  output  2  operand B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
ALUOp  output  2  00 = add, 01 = sub, 10 = funct decode
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
State  output  4  current state code, for debug and bench
IllegalOp  output  1  trap indicator

Behaviour:
- One 4-bit state register on clk; rst_n low forces state FETCH (0) asynchronously.
- While rst_n is low, all strobes are 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite.
- All selects are 0 except the values given for FETCH below. IllegalOp is 0.
- Outputs are decoded from state only. The exception is IRWrite and PCWrite in FETCH, which are qualified by MemReady.
- Any signal not listed for a state is 0.
- State codes and outputs:
  - FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=MemReady. Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
    - LW or SW -> MEMADR
    - RTYPE -> EXEC
    - BEQ -> BRANCH
    - J -> JUMP
    - ADDI -> ADDIEXEC
    - any other value -> see Optional Feature
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if Op=LW, otherwise MEMWR.
  - MEMRD (3): MemRead=1, IorD=1. Hold until MemReady=1, then go to MEMWB.
  - MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
  - MEMWR (5): MemWrite=1, IorD=1. Hold until MemReady=1, then go to FETCH.
  - EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - ALUWB (7): RegDst=1, MemtoReg=0, RegWrite=1. Go to FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
  - JUMP (9): PCWrite=1, PCSource=10. Go to FETCH.
  - ADDIEXEC (10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
  - ADDIWB (11): RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH.
  - TRAP (12): present only with the optional feature.
- Codes 13-15 are unreachable. If entered, the next state is FETCH with all outputs 0.
- Latency with MemReady held 1: beq = 3 cycles, j = 3, R-type = 4, addi = 4, sw = 4, lw = 5. Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemRead and MemWrite stay asserted, with constant IorD, for the whole stall.
- Op is sampled only in DECODE and MEMADR. Changes to Op in other states have no effect.
- Reset asserted mid-instruction: state returns to FETCH immediately, with no partial strobe after rst_n falls.
- First cycle after rst_n rises is FETCH with MemRead=1.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an unknown Op in DECODE goes to TRAP (12).
  - TRAP asserts IllegalOp=1, all strobes are 0, and the FSM stays in TRAP until reset.
- Undefined: an unknown Op in DECODE goes to FETCH, so the instruction behaves as a 2-cycle NOP.
  - TRAP does not exist, and IllegalOp is tied to 0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with MemReady=1 -> State=0 and all strobes 0. Release rst_n -> MemRead=1, IRWrite=1, PCWrite=1 in the first cycle.
- R-type: Op=6'h00, MemReady=1 -> State 0,1,6,7,0. ALUSrcA=0,0,1 in states 0,1,6 with ALUOp=10 in state 6. RegWrite=1 with RegDst=1 only in state 7.
- lw with stalls: Op=6'h23, MemReady=0 for 2 cycles in FETCH and 3 cycles in MEMRD.
  - Required state trace: 0,0,0,1,2,3,3,3,3,4,0 (10 cycles from the first FETCH cycle to the return to FETCH).
  - IRWrite pulses once; MemtoReg=1 with RegWrite=1 in state 4.
- beq then j: Op=6'h04 -> state 8 with PCWriteCond=1, PCSource=01, ALUOp=01. Then Op=6'h02 -> state 9 with PCWrite=1, PCSource=10. Each instruction takes 3 cycles.
- Illegal opcode Op=6'h3F:
  - ILLEGAL_OP_TRAP_EN defined -> State=12 and IllegalOp=1, held for 20 cycles, cleared only by rst_n.
  - Macro undefined -> state trace 0,1,0 with IllegalOp=0.
- Reset mid-sw: drop rst_n during MEMWR with MemReady=0 -> MemWrite falls to 0 in the same cycle, and State=0.
